// File: rtl/image_receiver.sv
// image_receiver: reassembles 24-bit RGB pixels from a UART byte stream.
// Frames are AA 55 <R G B>*N <xor checksum>. Each completed pixel is
// emitted as a single-cycle write strobe with a linear address. Inter-byte
// timeout, UART framing errors and a bad checksum all raise a sticky
// frame_err flag.
module image_receiver #(
    parameter int          WIDTH   = 640,
    parameter int          HEIGHT  = 480,
    parameter int          ADDR_W  = 19,
    parameter int          TIMEOUT = 50000,
    parameter logic [7:0]  SYNC0   = 8'hAA,
    parameter logic [7:0]  SYNC1   = 8'h55
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rx_err,
    output logic              pix_valid,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [7:0]        pix_r,
    output logic [7:0]        pix_g,
    output logic [7:0]        pix_b,
    output logic              frame_done,
    output logic              frame_err,
    output logic              busy,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SYNC  = 3'd1,
        RED   = 3'd2,
        GREEN = 3'd3,
        BLUE  = 3'd4,
        CHECK = 3'd5
    } state_t;

    localparam int                TO_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(WIDTH * HEIGHT - 1);

    state_t            cur;
    logic [ADDR_W-1:0] pix_cnt;
    logic [7:0]        csum;
    logic [TO_W-1:0]   tcnt;
    logic [7:0]        r_stage;
    logic [7:0]        g_stage;

    assign state = cur;
    assign busy  = (cur != IDLE);

    // Stage the red and green bytes until the blue byte completes the pixel.
    always_ff @(posedge clk) begin
        if (en && !rx_err && rx_valid) begin
            if (cur == RED)   r_stage <= rx_data;
            if (cur == GREEN) g_stage <= rx_data;
        end
    end

    // Frame FSM: sync detection, pixel assembly, checksum, timeout and abort handling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur        <= IDLE;
            pix_cnt    <= '0;
            csum       <= '0;
            tcnt       <= '0;
            pix_valid  <= 1'b0;
            pix_addr   <= '0;
            pix_r      <= '0;
            pix_g      <= '0;
            pix_b      <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            pix_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (!en) begin
                // Disabled: drop any partial frame silently, keep error/pixel outputs.
                cur  <= IDLE;
                tcnt <= '0;
            end else if (rx_err && cur != IDLE) begin
                // Framing error beats a coincident byte; the byte is discarded.
                cur       <= IDLE;
                tcnt      <= '0;
                frame_err <= 1'b1;
            end else if (rx_valid) begin
                tcnt <= '0;
                case (cur)
                    IDLE: begin
                        if (rx_data == SYNC0) cur <= SYNC;
                    end
                    SYNC: begin
                        if (rx_data == SYNC1) begin
                            cur       <= RED;
                            pix_cnt   <= '0;
                            csum      <= '0;
                            frame_err <= 1'b0;
                        end else if (rx_data != SYNC0) begin
                            cur <= IDLE;
                        end
                    end
                    RED: begin
                        csum <= csum ^ rx_data;
                        cur  <= GREEN;
                    end
                    GREEN: begin
                        csum <= csum ^ rx_data;
                        cur  <= BLUE;
                    end
                    BLUE: begin
                        csum      <= csum ^ rx_data;
                        pix_valid <= 1'b1;
                        pix_addr  <= pix_cnt;
                        pix_r     <= r_stage;
                        pix_g     <= g_stage;
                        pix_b     <= rx_data;
                        pix_cnt   <= pix_cnt + ADDR_W'(1);
                        cur       <= (pix_cnt == PIX_LAST) ? CHECK : RED;
                    end
                    CHECK: begin
                        if (rx_data == csum) frame_done <= 1'b1;
                        else                 frame_err  <= 1'b1;
                        cur <= IDLE;
                    end
                    default: cur <= IDLE;
                endcase
            end else if (cur != IDLE) begin
                // No byte this cycle: age the inter-byte timer.
                if (tcnt == TO_LAST) begin
                    cur       <= IDLE;
                    tcnt      <= '0;
                    frame_err <= 1'b1;
                end else begin
                    tcnt <= tcnt + TO_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_image_receiver.sv
// Testbench for image_receiver with a 2x1 frame and a short timeout.
module tb_image_receiver;

    localparam int W  = 2;
    localparam int H  = 1;
    localparam int AW = 4;
    localparam int TO = 100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_err = 1'b0;
    logic          pix_valid;
    logic [AW-1:0] pix_addr;
    logic [7:0]    pix_r, pix_g, pix_b;
    logic          frame_done, frame_err, busy;
    logic [2:0]    state;

    image_receiver #(
        .WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .TIMEOUT(TO),
        .SYNC0(8'hAA), .SYNC1(8'h55)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
        .pix_valid(pix_valid), .pix_addr(pix_addr),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .frame_done(frame_done), .frame_err(frame_err),
        .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    r, g, b;
        int            cyc;
    } pix_t;

    pix_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;
    int   cyc = 0;
    int   d0;

    // Observe the outputs produced at the last edge; pixels are scored here.
    task automatic mon();
        pix_t e;
        if (frame_done === 1'b1) done_cnt++;
        if (pix_valid === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pix addr=%0d rgb=%h_%h_%h cyc=%0d", pix_addr, pix_r, pix_g, pix_b, cyc);
            end else begin
                e = q.pop_front();
                if ({pix_addr, pix_r, pix_g, pix_b} !== {e.addr, e.r, e.g, e.b} || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL pixel got addr=%0d rgb=%h_%h_%h cyc=%0d expected addr=%0d rgb=%h_%h_%h cyc=%0d",
                             pix_addr, pix_r, pix_g, pix_b, cyc, e.addr, e.r, e.g, e.b, e.cyc);
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        mon();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        cycle();
        rx_valid = 1'b0;
    endtask

    task automatic send_pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                            input logic [AW-1:0] a, input bit expect_pix);
        pix_t e;
        send_byte(r);
        send_byte(g);
        if (expect_pix) begin
            e.addr = a; e.r = r; e.g = g; e.b = b; e.cyc = cyc + 1;
            q.push_back(e);
        end
        send_byte(b);
    endtask

    task automatic send_body(input logic [7:0] ck, input bit expect_pix);
        send_pix(8'h12, 8'h34, 8'h56, AW'(0), expect_pix);
        send_pix(8'hAB, 8'hCD, 8'hEF, AW'(1), expect_pix);
        send_byte(ck);
    endtask

    task automatic send_frame(input logic [7:0] ck, input bit expect_pix);
        send_byte(8'hAA);
        send_byte(8'h55);
        send_body(ck, expect_pix);
    endtask

    task automatic test_reset();
        repeat (3) cycle();
        checks++;
        if ({pix_valid, pix_addr, pix_r, pix_g, pix_b, frame_done, frame_err, busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got %b expected all zero",
                     {pix_valid, pix_addr, pix_r, pix_g, pix_b, frame_done, frame_err, busy});
        end
        checks++;
        if (state !== 3'd0) begin failures++; $display("FAIL reset_state got %0d expected 0", state); end
        rst_n = 1'b1;
        en    = 1'b1;
        cycle();
    endtask

    task automatic test_good_frame();
        d0 = done_cnt;
        send_frame(8'hF9, 1'b1);
        cycle();
        checks++;
        if (done_cnt != d0 + 1) begin failures++; $display("FAIL good_done got %0d expected %0d", done_cnt - d0, 1); end
        checks++;
        if (frame_err !== 1'b0) begin failures++; $display("FAIL good_err got %b expected 0", frame_err); end
        checks++;
        if (busy !== 1'b0 || state !== 3'd0) begin
            failures++; $display("FAIL good_idle got busy=%b state=%0d expected busy=0 state=0", busy, state);
        end
    endtask

    task automatic test_bad_checksum();
        d0 = done_cnt;
        send_frame(8'h00, 1'b1);
        cycle();
        checks++;
        if (done_cnt != d0) begin failures++; $display("FAIL bad_done got %0d expected 0", done_cnt - d0); end
        checks++;
        if (frame_err !== 1'b1) begin failures++; $display("FAIL bad_err got %b expected 1", frame_err); end
        send_byte(8'hAA);
        checks++;
        if (frame_err !== 1'b1) begin failures++; $display("FAIL err_sticky got %b expected 1", frame_err); end
        send_byte(8'h55);
        checks++;
        if (frame_err !== 1'b0) begin failures++; $display("FAIL err_clear got %b expected 0", frame_err); end
        d0 = done_cnt;
        send_body(8'hF9, 1'b1);
        checks++;
        if (done_cnt != d0 + 1) begin failures++; $display("FAIL recover_done got %0d expected 1", done_cnt - d0); end
    endtask

    task automatic test_header();
        d0 = done_cnt;
        send_byte(8'hAA);
        send_frame(8'hF9, 1'b1);
        checks++;
        if (done_cnt != d0 + 1 || frame_err !== 1'b0) begin
            failures++; $display("FAIL double_sync got done=%0d err=%b expected done=1 err=0", done_cnt - d0, frame_err);
        end
        d0 = done_cnt;
        send_byte(8'hAA);
        send_byte(8'h3C);
        checks++;
        if (state !== 3'd0) begin failures++; $display("FAIL bad_sync_state got %0d expected 0", state); end
        send_byte(8'h55);
        send_body(8'hF9, 1'b0);
        cycle();
        checks++;
        if (state !== 3'd0 || done_cnt != d0) begin
            failures++; $display("FAIL bad_sync_frame got state=%0d done=%0d expected state=0 done=0", state, done_cnt - d0);
        end
    endtask

    task automatic test_timeout();
        pix_t e;
        send_byte(8'hAA);
        send_byte(8'h55);
        send_byte(8'h12);
        repeat (TO - 1) cycle();
        checks++;
        if (state !== 3'd3 || frame_err !== 1'b0) begin
            failures++; $display("FAIL pre_timeout got state=%0d err=%b expected state=3 err=0", state, frame_err);
        end
        cycle();
        checks++;
        if (state !== 3'd0 || frame_err !== 1'b1) begin
            failures++; $display("FAIL timeout got state=%0d err=%b expected state=0 err=1", state, frame_err);
        end
        // Byte arriving exactly on the expiry cycle keeps the frame alive.
        d0 = done_cnt;
        send_byte(8'hAA);
        send_byte(8'h55);
        send_byte(8'h12);
        repeat (TO - 1) cycle();
        send_byte(8'h34);
        e.addr = AW'(0); e.r = 8'h12; e.g = 8'h34; e.b = 8'h56; e.cyc = cyc + 1;
        q.push_back(e);
        send_byte(8'h56);
        send_pix(8'hAB, 8'hCD, 8'hEF, AW'(1), 1'b1);
        send_byte(8'hF9);
        checks++;
        if (done_cnt != d0 + 1 || frame_err !== 1'b0) begin
            failures++; $display("FAIL keepalive got done=%0d err=%b expected done=1 err=0", done_cnt - d0, frame_err);
        end
    endtask

    task automatic test_rx_err();
        rx_err = 1'b1;
        cycle();
        rx_err = 1'b0;
        checks++;
        if (frame_err !== 1'b0 || state !== 3'd0) begin
            failures++; $display("FAIL idle_rx_err got err=%b state=%0d expected err=0 state=0", frame_err, state);
        end
        send_byte(8'hAA);
        send_byte(8'h55);
        send_byte(8'h12);
        rx_err = 1'b1;
        cycle();
        rx_err = 1'b0;
        checks++;
        if (state !== 3'd0 || frame_err !== 1'b1) begin
            failures++; $display("FAIL green_rx_err got state=%0d err=%b expected state=0 err=1", state, frame_err);
        end
        send_byte(8'hAA);
        send_byte(8'h55);
        send_byte(8'h12);
        send_byte(8'h34);
        rx_err  = 1'b1;
        rx_data = 8'h56;
        rx_valid = 1'b1;
        cycle();
        rx_err = 1'b0;
        rx_valid = 1'b0;
        cycle();
        checks++;
        if (state !== 3'd0 || frame_err !== 1'b1) begin
            failures++; $display("FAIL coincident_err got state=%0d err=%b expected state=0 err=1", state, frame_err);
        end
    endtask

    task automatic test_reset_mid();
        send_frame(8'hF9, 1'b1);
        send_byte(8'hAA);
        send_byte(8'h55);
        send_byte(8'h12);
        send_byte(8'h34);
        checks++;
        if (state !== 3'd4) begin failures++; $display("FAIL blue_state got %0d expected 4", state); end
        rx_data  = 8'h56;
        rx_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({pix_valid, pix_addr, pix_r, pix_g, pix_b, frame_done, frame_err, busy, state} !== '0) begin
            failures++;
            $display("FAIL mid_reset got %b expected all zero",
                     {pix_valid, pix_addr, pix_r, pix_g, pix_b, frame_done, frame_err, busy, state});
        end
        cycle();
        rx_valid = 1'b0;
        rst_n    = 1'b1;
        cycle();
        d0 = done_cnt;
        send_frame(8'hF9, 1'b1);
        checks++;
        if (done_cnt != d0 + 1) begin failures++; $display("FAIL post_reset_frame got %0d expected 1", done_cnt - d0); end
    endtask

    task automatic test_en_low();
        send_byte(8'hAA);
        send_byte(8'h55);
        send_byte(8'h12);
        send_byte(8'h34);
        en       = 1'b0;
        rx_data  = 8'h56;
        rx_valid = 1'b1;
        cycle();
        rx_valid = 1'b0;
        cycle();
        checks++;
        if (state !== 3'd0 || busy !== 1'b0) begin
            failures++; $display("FAIL en_low_state got state=%0d busy=%b expected 0/0", state, busy);
        end
        checks++;
        if (pix_addr !== AW'(1) || pix_b !== 8'hEF || frame_err !== 1'b0) begin
            failures++; $display("FAIL en_low_hold got addr=%0d b=%h err=%b expected 1/ef/0", pix_addr, pix_b, frame_err);
        end
        en = 1'b1;
        cycle();
        d0 = done_cnt;
        send_frame(8'hF9, 1'b1);
        checks++;
        if (done_cnt != d0 + 1) begin failures++; $display("FAIL post_en_frame got %0d expected 1", done_cnt - d0); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_header();
        test_timeout();
        test_rx_err();
        test_reset_mid();
        test_en_low();
        repeat (3) cycle();
        checks++;
        if (q.size() != 0) begin failures++; $display("FAIL missing_pix got %0d outstanding expected 0", q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
